// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_DATA  = 3'd1,
    ST_CRC   = 3'd2,
    ST_CHECK = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CRC  = 2'b01;

  // Number of whole bytes needed to carry the given number of config bits.
  function automatic int unsigned num_bytes(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// One byte step of CRC-8 (MSB first, unreflected, no final XOR).
module cfg_crc8
  import cfg_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = {c[6:0], 1'b0} ^ (c[7] ? CRC_POLY : 8'h00);
    end
    crc_out = c;
  end

endmodule

// File: rtl/cfg_loader.sv
// Receives a framed, CRC-protected bitstream and commits it atomically to prog.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int unsigned CFG_BITS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CFG_BITS-1:0] prog,
  output logic                cfg_valid,
  output logic                done,
  output logic                busy,
  output logic [1:0]          err
);

  localparam int unsigned NB = num_bytes(CFG_BITS);
  localparam int unsigned SW = 8 * NB;
  localparam int unsigned CW = $clog2(NB + 1);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] shadow;
  logic [CW-1:0] cnt;
  logic [7:0]    crc;
  logic [7:0]    crc_step;
  logic [7:0]    rx_crc;
  logic          accept;

  logic          data_ld;
  logic          rx_ld;
  logic          frame_clr;
  logic          commit;
  logic          set_err;
  logic          clr_err;

  cfg_crc8 u_crc8 (
    .crc_in  (crc),
    .data    (in_data),
    .crc_out (crc_step)
  );

  // Restart and reset both block the byte handshake in the same cycle.
  assign in_ready = !rst && !start &&
                    (state == ST_SYNC || state == ST_DATA || state == ST_CRC);
  assign accept   = in_valid && in_ready;

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    data_ld   = 1'b0;
    rx_ld     = 1'b0;
    frame_clr = 1'b0;
    commit    = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    if (start) begin
      state_nxt = ST_SYNC;
      frame_clr = 1'b1;
      clr_err   = 1'b1;
    end else begin
      case (state)
        ST_SYNC: begin
          if (accept && in_data == SYNC_BYTE) begin
            state_nxt = ST_DATA;
            frame_clr = 1'b1;
          end
        end
        ST_DATA: begin
          if (accept) begin
            data_ld = 1'b1;
            if (cnt == CW'(NB - 1)) state_nxt = ST_CRC;
          end
        end
        ST_CRC: begin
          if (accept) begin
            rx_ld     = 1'b1;
            state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (rx_crc == crc) begin
            commit    = 1'b1;
            state_nxt = ST_SYNC;
          end else begin
            set_err   = 1'b1;
            state_nxt = ST_ERROR;
          end
        end
        ST_ERROR: state_nxt = ST_ERROR;
        default:  state_nxt = ST_SYNC;
      endcase
    end
  end

  // State register, shadow/CRC datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SYNC;
      shadow    <= '0;
      cnt       <= '0;
      crc       <= '0;
      rx_crc    <= '0;
      prog      <= '0;
      cfg_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= ERR_NONE;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_DATA) || (state_nxt == ST_CRC) ||
               (state_nxt == ST_CHECK);
      done  <= commit;

      if (frame_clr)    cnt <= '0;
      else if (data_ld) cnt <= cnt + CW'(1);

      if (frame_clr)    crc <= '0;
      else if (data_ld) crc <= crc_step;

      // First byte ends up most significant; pad bits fall off the top at commit.
      if (data_ld) shadow <= (shadow << 8) | SW'(in_data);
      if (rx_ld)   rx_crc <= in_data;

      if (commit) begin
        prog      <= shadow[CFG_BITS-1:0];
        cfg_valid <= 1'b1;
      end

      if (clr_err)      err <= ERR_NONE;
      else if (set_err) err <= ERR_CRC;
    end
  end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter CFG_BITS, default 64, total configuration bits driven to a node fabric (>=8).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  synchronous restart pulse; abandons load, clears error.
REQ-005 SHALL have port in_data  input  8  bitstream byte.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts byte; transfer = in_valid && in_ready.
REQ-008 SHALL have port prog  output  CFG_BITS  configuration vector to node arrays.
REQ-009 SHALL have port cfg_valid  output  1  prog holds a CRC-checked image.
REQ-010 SHALL have port done  output  1  one-cycle pulse on commit.
REQ-011 SHALL have port busy  output  1  high in DATA, CRC, CHECK.
REQ-012 SHALL have port err  output  2  00 none, 01 CRC mismatch; sticky until start or rst.

Function
REQ-013 Frame SHALL be: sync byte 0xA5, NB = ceil(CFG_BITS/8) data bytes, one CRC-8 byte.
REQ-014 States SHALL be SYNC, DATA, CRC, CHECK, ERROR; in_ready = 1 in SYNC/DATA/CRC, else 0.
REQ-015 SYNC: accepted 0xA5 -> DATA, byte counter cleared; any other byte discarded, stay SYNC.
REQ-016 DATA: each accepted byte shifts into shadow register from LSB end (first byte ends most significant); after NB-th byte -> CRC.
REQ-017 Upper 8*NB-CFG_BITS bits of first data byte SHALL be discarded (pad).
REQ-018 CRC-8: poly 0x07, init 0x00, MSB-first, no reflection, no final XOR, over data bytes only.
REQ-019 CRC: accepted byte -> CHECK; CHECK lasts exactly one cycle.
REQ-020 CHECK match: at next edge prog <= shadow, cfg_valid <= 1, done = 1 for that cycle, -> SYNC.
REQ-021 CHECK mismatch: prog and cfg_valid unchanged, err <= 01, -> ERROR.
REQ-022 ERROR: hold until start; start -> SYNC, err <= 00.
REQ-023 prog SHALL change only at commit; never reflects partial shadow contents.
REQ-024 start in any state -> SYNC next edge, counter and CRC cleared, prog/cfg_valid unchanged.
REQ-025 start high SHALL force in_ready = 0 that cycle (no byte accepted alongside restart).
REQ-026 in_valid low SHALL stall with no state change; gaps between bytes unlimited.
REQ-027 Reload after commit SHALL be permitted; old prog held until new commit.
REQ-028 Latency: CRC byte accepted at edge N -> prog/done/cfg_valid updated at edge N+2.

Reset
REQ-029 rst SHALL asynchronously force: state SYNC, prog = 0, cfg_valid = 0, done = 0, err = 00, shadow/counter/CRC = 0.
REQ-030 in_ready SHALL be 0 while rst high, 1 from first cycle after release; busy = 0.
REQ-031 rst mid-frame SHALL discard the frame; prog = 0 (all nodes pass-through/off).

Structure
REQ-032 Shared package cfg_pkg SHALL hold state enum, SYNC_BYTE = 8'hA5, CRC_POLY = 8'h07, err code constants.
REQ-033 One sub-module cfg_crc8 (combinational byte step: crc_in, data -> crc_out) SHALL be instantiated.
REQ-034 Byte counter width SHALL be $clog2(NB+1).

Verification (CFG_BITS = 16 unless noted)
REQ-035 Bytes A5 12 34 F1 back-to-back -> prog = 16'h1234, cfg_valid = 1, done one cycle 2 edges after F1 accepted, err = 00.
REQ-036 Bytes A5 12 34 00 -> err = 01, prog = 0, cfg_valid = 0, in_ready = 0 until start; after start, A5 12 34 F1 -> prog = 16'h1234.
REQ-037 Bytes 00 FF A5 12 34 F1 with random in_valid gaps -> leading bytes ignored, prog = 16'h1234.
REQ-038 After good load, send A5 12 then start, then A5 12 34 F1 -> prog stays 16'h1234 throughout, no error; start cycle accepts no byte.
REQ-039 rst asserted after A5 12 34 accepted (mid-clock) -> prog = 0, cfg_valid = 0 immediately; next frame loads normally.
REQ-040 CFG_BITS = 12: A5 F1 23 + correct CRC over F1 23 -> prog = 12'h123 (pad nibble F dropped).
